// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and widths for the pipeline hazard sequencer.
// Optional bubble counter is enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FLUSH = 2'd1,
    CTRL_STALL = 2'd2,
    CTRL_SLEEP = 2'd3
  } ctrl_state_t;

  localparam int CNT_W    = 3;
  localparam int BUBBLE_W = 16;

  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BUBBLE_W-1:0] BUBBLE_MAX = {BUBBLE_W{1'b1}};

  // Saturating increment for the bubble statistics counter.
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] val);
    logic [BUBBLE_W-1:0] res;
    if (val == BUBBLE_MAX) begin
      res = val;
    end else begin
      res = val + {{(BUBBLE_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_flush_cnt.sv
// Loadable down counter that tracks the remaining squash cycles of a flush.
// Load wins over decrement; the count never goes below zero.
module pipe_flush_cnt
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: reset, load, or decrement while enabled and nonzero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: squash/hold decode for IF/ID/EX, PC hold, sleep/wake.
// Define PIPE_HAZARD_CTRL_PERF_EN to add the bubble_cnt statistics output.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int SKIP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       br_taken,
  input  logic       skip_taken,
  input  logic       sleep_req,
  input  logic       wake,
  input  logic       mem_wait,
  output logic       pc_hold,
  output logic       if_clr,
  output logic       id_clr,
  output logic       ex_clr,
  output logic       if_cls,
  output logic       id_cls,
  output logic       ex_cls,
  output logic [1:0] ctrl_state,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [BUBBLE_W-1:0] bubble_cnt,
`endif
  output logic       sleeping
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SKIP_LOAD  = CNT_W'(SKIP_CYCLES - 1);

  ctrl_state_t      state_r, nxt_state_s;
  logic             skip_r, nxt_skip_s;
  logic             cnt_load_s, cnt_en_s, cnt_zero_s;
  logic [CNT_W-1:0] cnt_load_val_s, cnt_s;

  pipe_flush_cnt u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Mealy decode: outputs and next state from registered state plus inputs.
  always_comb begin
    pc_hold        = 1'b0;
    if_clr         = 1'b0;
    id_clr         = 1'b0;
    ex_clr         = 1'b0;
    if_cls         = 1'b0;
    id_cls         = 1'b0;
    ex_cls         = 1'b0;
    nxt_state_s    = state_r;
    nxt_skip_s     = skip_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = CNT_ZERO;
    cnt_en_s       = 1'b0;
    if (rst) begin
      pc_hold     = 1'b1;
      if_clr      = 1'b1;
      id_clr      = 1'b1;
      ex_clr      = 1'b1;
      nxt_state_s = CTRL_RUN;
      nxt_skip_s  = 1'b0;
    end else begin
      case (state_r)
        // STALL with mem_wait low is exactly RUN, so both share one decode.
        CTRL_RUN, CTRL_STALL: begin
          if (mem_wait) begin
            pc_hold     = 1'b1;
            if_cls      = 1'b1;
            id_cls      = 1'b1;
            ex_cls      = 1'b1;
            nxt_state_s = CTRL_STALL;
          end else if (sleep_req) begin
            ex_clr      = 1'b1;
            nxt_state_s = CTRL_SLEEP;
          end else if (br_taken) begin
            if_clr     = 1'b1;
            id_clr     = 1'b1;
            nxt_skip_s = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              nxt_state_s    = CTRL_FLUSH;
              cnt_load_s     = 1'b1;
              cnt_load_val_s = FLUSH_LOAD;
            end else begin
              nxt_state_s = CTRL_RUN;
            end
          end else if (skip_taken) begin
            id_clr = 1'b1;
            if (SKIP_CYCLES > 1) begin
              nxt_state_s    = CTRL_FLUSH;
              nxt_skip_s     = 1'b1;
              cnt_load_s     = 1'b1;
              cnt_load_val_s = SKIP_LOAD;
            end else begin
              nxt_state_s = CTRL_RUN;
            end
          end else begin
            nxt_state_s = CTRL_RUN;
          end
        end
        CTRL_FLUSH: begin
          if (mem_wait) begin
            pc_hold = 1'b1;
            if_cls  = 1'b1;
            id_cls  = 1'b1;
            ex_cls  = 1'b1;
          end else if (sleep_req) begin
            if_clr      = ~skip_r;
            id_clr      = 1'b1;
            ex_clr      = 1'b1;
            nxt_state_s = CTRL_SLEEP;
            nxt_skip_s  = 1'b0;
          end else if (br_taken) begin
            if_clr     = 1'b1;
            id_clr     = 1'b1;
            nxt_skip_s = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              cnt_load_s     = 1'b1;
              cnt_load_val_s = FLUSH_LOAD;
            end else begin
              nxt_state_s = CTRL_RUN;
            end
          end else begin
            if_clr   = ~skip_r;
            id_clr   = 1'b1;
            cnt_en_s = 1'b1;
            if (cnt_zero_s || (cnt_s == CNT_ONE)) begin
              nxt_state_s = CTRL_RUN;
              nxt_skip_s  = 1'b0;
            end else begin
              nxt_state_s = CTRL_FLUSH;
            end
          end
        end
        CTRL_SLEEP: begin
          pc_hold = 1'b1;
          if_cls  = 1'b1;
          id_cls  = 1'b1;
          ex_clr  = 1'b1;
          if (wake) begin
            nxt_state_s = CTRL_RUN;
          end else begin
            nxt_state_s = CTRL_SLEEP;
          end
        end
        default: begin
          nxt_state_s = CTRL_RUN;
          nxt_skip_s  = 1'b0;
        end
      endcase
    end
  end

  // State and skip-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CTRL_RUN;
      skip_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      skip_r  <= nxt_skip_s;
    end
  end

  assign ctrl_state = state_r;
  assign sleeping   = (state_r == CTRL_SLEEP);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [BUBBLE_W-1:0] bubble_r;
  logic                bubble_s;

  assign bubble_s = if_clr | id_clr | ex_clr | if_cls | id_cls | ex_cls;

  // Saturating count of cycles that inject a bubble or hold a stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_r <= {BUBBLE_W{1'b0}};
    end else if (bubble_s) begin
      bubble_r <= sat_inc(bubble_r);
    end else begin
      bubble_r <= bubble_r;
    end
  end

  assign bubble_cnt = bubble_r;
`endif

endmodule
